// File: rtl/ascon_data_buffer_if.sv
// Host word window plus core block request/return signals of ascon_data_buffer.
// slave = buffer side, master = host/core side.
interface ascon_data_buffer_if #(parameter int AW = 5);
   logic [AW-1:0] wb_addr;
   logic [31:0]   datain_wb;
   logic          mem_we;
   logic [31:0]   mem_rdata;
   logic          start;
   logic [4:0]    AD_len;
   logic [7:0]    datalen;
   logic          block_request;
   logic [63:0]   CTblock;
   logic          CTv;
   logic [63:0]   blockout;
   logic          block_valid;
   logic          block_is_ad;
   logic          block_last;
   logic          buf_err;

   modport slave (
      input  wb_addr, datain_wb, mem_we, start, AD_len, datalen, block_request, CTblock, CTv,
      output mem_rdata, blockout, block_valid, block_is_ad, block_last, buf_err
   );
   modport master (
      output wb_addr, datain_wb, mem_we, start, AD_len, datalen, block_request, CTblock, CTv,
      input  mem_rdata, blockout, block_valid, block_is_ad, block_last, buf_err
   );
endinterface

// File: rtl/ascon_data_buffer.sv
// AD/message word store: issues padded 64-bit blocks one cycle after block_request (no stall), CT writeback in place.
// ASCON_BUF_LOCK_EN: host reads/writes blocked while the block walk is active.
module ascon_data_buffer #(
   parameter int DEPTH_W = 32,
   parameter int AW      = $clog2(DEPTH_W)
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   ascon_data_buffer_if.slave   bus
);
   localparam int BW   = AW - 1;
   localparam int NBLK = DEPTH_W / 2;

   typedef enum logic [2:0] {S_IDLE, S_CHK, S_AD, S_MSG, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_mem [DEPTH_W];
   logic [4:0]    r_ad_len;
   logic [6:0]    r_dlen;
   logic [BW-1:0] r_blk;
   logic [4:0]    r_cnt;
   logic [BW-1:0] r_wb_blk;
   logic [3:0]    r_wb_n;
   logic          r_wb_ok;
   logic [63:0]   r_blockout;
   logic          r_block_valid, r_is_ad, r_last, r_buf_err;

   logic [2:0]    w_nad;
   logic [4:0]    w_nm, w_phase_n;
   logic          w_over, w_issue, w_in_ad, w_cnt_last, w_ct_wr, w_host_wr, w_lock;
   logic [2:0]    w_rem;
   logic [63:0]   w_raw, w_padded;

   assign w_nad      = (r_ad_len != 5'd0) ? {1'b0, r_ad_len[4:3]} + 3'd1 : 3'd0;
   assign w_nm       = {1'b0, r_dlen[6:3]} + 5'd1;
   assign w_over     = ({3'b0, w_nad} + {1'b0, w_nm}) > 6'(NBLK);
   assign w_in_ad    = (r_state == S_AD);
   assign w_issue    = bus.block_request && !bus.start && (w_in_ad || r_state == S_MSG);
   assign w_phase_n  = w_in_ad ? {2'b0, w_nad} : w_nm;
   assign w_cnt_last = (r_cnt == w_phase_n - 5'd1);
   assign w_rem      = w_in_ad ? r_ad_len[2:0] : r_dlen[2:0];
   assign w_raw      = {r_mem[{r_blk, 1'b0}], r_mem[{r_blk, 1'b1}]};
   assign w_ct_wr    = bus.CTv && r_wb_ok && !bus.start && (r_state == S_MSG || r_state == S_DONE);

`ifdef ASCON_BUF_LOCK_EN
   assign w_lock = (r_state == S_CHK) || (r_state == S_AD) || (r_state == S_MSG);
`else
   assign w_lock = 1'b0;
`endif
   assign w_host_wr = !bus.mem_we && !w_lock;

   // Only the final block of a phase is padded: r data bytes, 0x80, then zeros.
   always_comb begin
      w_padded = 64'd0;
      for (int k = 0; k < 8; k++) begin
         if (!w_cnt_last || k < int'(w_rem)) w_padded[63-8*k -: 8] = w_raw[63-8*k -: 8];
         else if (k == int'(w_rem))          w_padded[63-8*k -: 8] = 8'h80;
         else                                w_padded[63-8*k -: 8] = 8'h00;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.start) begin
         w_state_nxt = S_CHK;
      end else begin
         case (r_state)
            S_CHK:   w_state_nxt = w_over ? S_DONE : ((w_nad != 3'd0) ? S_AD : S_MSG);
            S_AD:    if (w_issue && w_cnt_last) w_state_nxt = S_MSG;
            S_MSG:   if (w_issue && w_cnt_last) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state       <= S_IDLE;
         r_ad_len      <= 5'd0;
         r_dlen        <= 7'd0;
         r_blk         <= '0;
         r_cnt         <= 5'd0;
         r_wb_blk      <= '0;
         r_wb_n        <= 4'd0;
         r_wb_ok       <= 1'b0;
         r_blockout    <= 64'd0;
         r_block_valid <= 1'b0;
         r_is_ad       <= 1'b0;
         r_last        <= 1'b0;
         r_buf_err     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_block_valid <= w_issue;
         if (bus.start) begin
            r_ad_len  <= bus.AD_len;
            r_dlen    <= 7'(bus.datalen & 8'h7F);
            r_blk     <= '0;
            r_cnt     <= 5'd0;
            r_wb_ok   <= 1'b0;
            r_buf_err <= 1'b0;
         end else begin
            if (r_state == S_CHK && w_over) r_buf_err <= 1'b1;
            if (w_issue) begin
               r_blk      <= r_blk + 1'b1;
               r_cnt      <= w_cnt_last ? 5'd0 : r_cnt + 5'd1;
               r_blockout <= w_padded;
               r_is_ad    <= w_in_ad;
               r_last     <= w_cnt_last;
               if (!w_in_ad) begin
                  r_wb_blk <= r_blk;
                  r_wb_n   <= w_cnt_last ? {1'b0, r_dlen[2:0]} : 4'd8;
                  r_wb_ok  <= 1'b1;
               end
            end
         end
      end
   end

   // CT bytes are assigned after the host word so they win on a same-cycle collision.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int w = 0; w < DEPTH_W; w++) r_mem[w] <= 32'd0;
      end else begin
         if (w_host_wr) r_mem[bus.wb_addr] <= bus.datain_wb;
         if (w_ct_wr) begin
            for (int j = 0; j < 4; j++) begin
               if (4'(j) < r_wb_n)
                  r_mem[{r_wb_blk, 1'b0}][31-8*j -: 8] <= bus.CTblock[63-8*j -: 8];
               if (4'(j + 4) < r_wb_n)
                  r_mem[{r_wb_blk, 1'b1}][31-8*j -: 8] <= bus.CTblock[31-8*j -: 8];
            end
         end
      end
   end

   assign bus.mem_rdata   = w_lock ? 32'd0 : r_mem[bus.wb_addr];
   assign bus.blockout    = r_blockout;
   assign bus.block_valid = r_block_valid;
   assign bus.block_is_ad = r_is_ad;
   assign bus.block_last  = r_last;
   assign bus.buf_err     = r_buf_err;
endmodule

// File: tb/tb_ascon_data_buffer.sv
// Randomized bench for ascon_data_buffer against a byte-stream model of AD/message padding and writeback.
`timescale 1ns/1ps
module tb_ascon_data_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ascon_data_buffer_if bif();
   ascon_data_buffer dut (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bif));

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] m_mem [128];
   int m_adl, m_dl;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nad(input int l);
      return (l != 0) ? l / 8 + 1 : 0;
   endfunction

   function automatic int nm(input int l);
      return (l % 128) / 8 + 1;
   endfunction

   function automatic logic [31:0] model_word(input int w);
      return {m_mem[4*w], m_mem[4*w+1], m_mem[4*w+2], m_mem[4*w+3]};
   endfunction

   // Phase is a byte stream of length L starting at byte base; past L comes 0x80 then zeros.
   function automatic logic [63:0] exp_block(input bit is_ad, input int j);
      logic [63:0] b;
      int base, len, p;
      base = is_ad ? 0 : 8 * nad(m_adl);
      len  = is_ad ? m_adl : m_dl;
      b = 64'd0;
      for (int k = 0; k < 8; k++) begin
         p = 8 * j + k;
         if (p < len)       b[63-8*k -: 8] = m_mem[base + p];
         else if (p == len) b[63-8*k -: 8] = 8'h80;
      end
      return b;
   endfunction

   task automatic model_host(input int w, input logic [31:0] d);
      for (int j = 0; j < 4; j++) m_mem[4*w+j] = d[31-8*j -: 8];
   endtask

   task automatic model_ct(input int j, input logic [63:0] ct);
      int base;
      base = 8 * nad(m_adl);
      for (int k = 0; k < 8; k++)
         if (8 * j + k < m_dl) m_mem[base + 8*j + k] = ct[63-8*k -: 8];
   endtask

   task automatic host_write(input int w, input logic [31:0] d);
      bif.wb_addr   = 5'(w);
      bif.datain_wb = d;
      bif.mem_we    = 1'b0;
      tick();
      bif.mem_we    = 1'b1;
      model_host(w, d);
   endtask

   task automatic read_check(input string tag, input int w);
      bif.wb_addr = 5'(w);
      #1;
      check($sformatf("%s[%0d]", tag, w), bif.mem_rdata, model_word(w));
   endtask

   task automatic do_start(input int adl, input int dl);
      bif.AD_len  = 5'(adl);
      bif.datalen = 8'(dl);
      m_adl = adl;
      m_dl  = dl % 128;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      tick();
   endtask

   // Leaves block_request high so the caller can chain back-to-back issues.
   task automatic issue(input string tag, input bit is_ad, input int j);
      int n;
      n = is_ad ? nad(m_adl) : nm(m_dl);
      bif.block_request = 1'b1;
      tick();
      check({tag, "_vld"}, bif.block_valid, 1'b1);
      check({tag, "_dat"}, bif.blockout, exp_block(is_ad, j));
      check({tag, "_ad"}, bif.block_is_ad, is_ad);
      check({tag, "_last"}, bif.block_last, (j == n - 1));
   endtask

   task automatic send_ct(input int j, input logic [63:0] ct);
      bif.block_request = 1'b0;
      bif.CTblock = ct;
      bif.CTv = 1'b1;
      tick();
      bif.CTv = 1'b0;
      model_ct(j, ct);
   endtask

   task automatic expect_no_valid(input string tag);
      bif.block_request = 1'b1;
      tick();
      bif.block_request = 1'b0;
      check(tag, bif.block_valid, 1'b0);
   endtask

   task automatic run(input int adl, input int dl);
      bit over;
      do_start(adl, dl);
      over = (nad(m_adl) + nm(m_dl)) > 16;
      check("buf_err", bif.buf_err, over);
      if (over) begin
         expect_no_valid("err_no_valid");
      end else begin
         for (int j = 0; j < nad(m_adl); j++) begin
            issue($sformatf("ad%0d", j), 1'b1, j);
            if ($urandom_range(1, 0) == 1) begin
               bif.block_request = 1'b0;
               tick();
            end
         end
         for (int j = 0; j < nm(m_dl); j++) begin
            issue($sformatf("msg%0d", j), 1'b0, j);
            if ($urandom_range(1, 0) == 1) send_ct(j, {$urandom, $urandom});
            else if ($urandom_range(1, 0) == 1) begin
               bif.block_request = 1'b0;
               tick();
            end
         end
         bif.block_request = 1'b0;
         tick();
         expect_no_valid("done_no_valid");
      end
      for (int w = 0; w < 32; w++) read_check("rb", w);
   endtask

   initial begin
      int adl, dl;
      bif.wb_addr = '0; bif.datain_wb = '0; bif.mem_we = 1'b1; bif.start = 1'b0;
      bif.AD_len = '0; bif.datalen = '0; bif.block_request = 1'b0;
      bif.CTblock = '0; bif.CTv = 1'b0;
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
      repeat (2) tick();
      check("rst_blockout", bif.blockout, 64'd0);
      check("rst_valid", bif.block_valid, 1'b0);
      check("rst_is_ad", bif.block_is_ad, 1'b0);
      check("rst_last", bif.block_last, 1'b0);
      check("rst_err", bif.buf_err, 1'b0);
      for (int w = 0; w < 32; w++) read_check("rst_mem", w);
      rst_n = 1'b1;
      tick();

      // AD 5 bytes, 16 message bytes
      host_write(0, 32'h01020304);
      host_write(1, 32'h05000000);
      for (int w = 2; w < 8; w++) host_write(w, $urandom);
      do_start(5, 16);
      check("t2_err", bif.buf_err, 1'b0);
      issue("t2_ad", 1'b1, 0);
      check("t2_ad_const", bif.blockout, 64'h0102030405800000);
      issue("t2_m0", 1'b0, 0);
      issue("t2_m1", 1'b0, 1);
      issue("t2_m2", 1'b0, 2);
      check("t2_pad_const", bif.blockout, 64'h8000000000000000);
      bif.block_request = 1'b0;
      tick();
      expect_no_valid("t2_done");

      // no AD, 3 message bytes, then writeback and collision
      host_write(0, 32'h11223344);
      host_write(1, 32'h99887766);
      do_start(0, 3);
      issue("t3", 1'b0, 0);
      check("t3_const", bif.blockout, 64'h1122338000000000);
      send_ct(0, 64'hAABBCCDDEEFF0011);
      read_check("t4_wb", 0);
      check("t4_w0_const", bif.mem_rdata, 32'hAABBCC44);
      read_check("t4_w1", 1);
      check("t4_w1_const", bif.mem_rdata, 32'h99887766);
      bif.wb_addr = 5'd0; bif.datain_wb = 32'h55667788; bif.mem_we = 1'b0;
      model_host(0, 32'h55667788);
      send_ct(0, 64'h123456789ABCDEF0);
      bif.mem_we = 1'b1;
      read_check("t4_coll", 0);
      check("t4_coll_const", bif.mem_rdata, 32'h12345688);

      // overflow, then legal restart clears the error
      do_start(31, 127);
      check("t5_err", bif.buf_err, 1'b1);
      expect_no_valid("t5_no_valid");
      do_start(5, 16);
      check("t5_err_clr", bif.buf_err, 1'b0);

      // host access during a message walk
      do_start(0, 20);
      issue("t6_m0", 1'b0, 0);
      bif.block_request = 1'b0;
      bif.wb_addr = 5'd5; bif.datain_wb = 32'hDEADBEEF; bif.mem_we = 1'b0;
      tick();
      bif.mem_we = 1'b1;
`ifdef ASCON_BUF_LOCK_EN
      bif.wb_addr = 5'd0;
      #1;
      check("t6_lock_rd", bif.mem_rdata, 32'd0);
`else
      model_host(5, 32'hDEADBEEF);
      read_check("t6_live_rd", 5);
`endif
      issue("t6_m1", 1'b0, 1);
      issue("t6_m2", 1'b0, 2);
      bif.block_request = 1'b0;
      tick();
      read_check("t6_after", 5);

      for (int r = 0; r < 25; r++) begin
         adl = $urandom_range(31, 0);
         if ($urandom_range(3, 0) == 0) dl = $urandom_range(255, 0);
         else dl = $urandom_range(8 * (16 - nad(adl)) - 1, 0);
         for (int i = 0; i < 8; i++) host_write($urandom_range(31, 0), $urandom);
         if ($urandom_range(3, 0) == 0) begin
            do_start(adl, dl);
            if (nad(m_adl) + nm(m_dl) <= 16) begin
               issue("restart_first", nad(m_adl) > 0, 0);
               bif.block_request = 1'b0;
            end
         end
         run(adl, dl);
      end

      // reset in the middle of a message walk
      for (int w = 0; w < 16; w++) host_write(w, $urandom);
      do_start(0, 40);
      issue("t1_m0", 1'b0, 0);
      bif.block_request = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
      check("t1_blockout", bif.blockout, 64'd0);
      check("t1_valid", bif.block_valid, 1'b0);
      check("t1_is_ad", bif.block_is_ad, 1'b0);
      check("t1_last", bif.block_last, 1'b0);
      check("t1_err", bif.buf_err, 1'b0);
      for (int w = 0; w < 32; w++) read_check("t1_mem", w);
      tick();
      rst_n = 1'b1;
      expect_no_valid("t1_idle_no_valid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
